mips_fetch_unit: RTL and testbench
==================================

# mips_fetch_unit

Parametrised instruction-fetch stage for the MIPS single-cycle core. It owns a byte-addressed, big-endian instruction memory, a program-counter register and next-PC selection (sequential, beq-taken, jump), and presents the current instruction and its IMEM byte address to the decode/execute datapath. It replaces hand-driven `ReadAddr` sequencing. It also adds a load phase, stall, a range-fault stop and a retired-instruction counter.

## Interface
Parameters:
- `ADDR_W`, 8: IMEM byte-address width; IMEM holds 2**ADDR_W bytes.
- `TEXT_BASE`, 32'h0040_0000: architectural PC that maps to IMEM byte 0; reset PC.
- `CNT_W`, 32: width of retired-instruction counter.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `load_we`  in  1: IMEM byte write strobe; honoured only in LOAD.
- `load_addr`  in  ADDR_W: IMEM byte address for load.
- `load_data`  in  8: byte to write.
- `start`  in  1: LOAD→RUN request.
- `stall`  in  1: hold PC and counter this cycle; honoured only in RUN.
- `Branch`  in  1: decoder says current instruction is beq.
- `Zero`  in  1: ALU zero flag for the current instruction.
- `SEImm`  in  32: sign-extended immediate of the current instruction.
- `Jump`  in  1: decoder says current instruction is j.
- `JumpValue`  in  26: instr[25:0] of the current instruction.
- `PC`  out  32: architectural PC.
- `ReadAddr`  out  ADDR_W: (PC − TEXT_BASE)[ADDR_W-1:0].
- `Instr`  out  32: {IM[a],IM[a+1],IM[a+2],IM[a+3]}, where a = ReadAddr; the address wraps modulo 2**ADDR_W.
- `InstrValid`  out  1: high only in RUN.
- `Fault`  out  1: high in FAULT.
- `Retired`  out  CNT_W: count of instructions retired.

## Operation
- States: LOAD (reset state), RUN, FAULT.
- LOAD: `load_we`=1 writes `load_data` to IM[`load_addr`] at the edge. PC is held. `start`=1 → RUN on the next edge. A write and `start` in the same cycle both take effect.
- RUN: `load_we` and `start` are ignored. At each edge with `stall`=0, the next PC is selected with this priority:
  - Jump=1: {PC4[31:28], JumpValue, 2'b00}.
  - Branch=1 & Zero=1: PC4 + (SEImm << 2), where PC4 = PC + 4. All arithmetic is mod 2**32.
  - Otherwise: PC4.
- Range check: off = next_PC − TEXT_BASE, computed mod 2**32. If off ≥ 2**ADDR_W:
  - go to FAULT;
  - PC stays at the offending instruction;
  - `Retired` is not incremented.
- Otherwise PC ← next_PC and `Retired` increments. `Retired` saturates at all-ones.
- `stall`=1 in RUN: PC, `Retired` and state are held; `Instr` stays stable.
- FAULT: terminal state; only `reset` leaves it. PC and `Retired` are frozen.
- Branch with Zero=0 is not taken and falls through to PC4.
- IMEM contents are not cleared by reset.

## Timing
- Reset values (asynchronous, immediate): state=LOAD, PC=TEXT_BASE, ReadAddr=0, InstrValid=0, Fault=0, Retired=0.
- Reset asserted mid-RUN aborts immediately. After reset the block restarts in LOAD with the existing IMEM contents.
- `Instr` is combinational from ReadAddr and IMEM. Latency from a PC update to a valid `Instr` is 0 cycles.
- Decoder inputs (Branch, Zero, SEImm, Jump, JumpValue) must be settled before the edge that consumes them. Each instruction takes exactly one cycle when unstalled.
- An IMEM write in LOAD is visible on `Instr` in the cycle after the edge.
- LOAD→RUN takes 1 edge. `InstrValid` rises in the first cycle after that edge.
- RUN→FAULT takes 1 edge. `Fault` is high from the next cycle, and `InstrValid` drops in the same cycle.

## Test plan
- Reset/load: assert `reset`, then load 28 bytes holding 02CDF824, 0043082A, 8E8C0014, AC040000, 10A6FFFF, 01093822, 08100004 at addresses 0..27, then pulse `start`. Required: PC=0x00400000, Instr=0x02CDF824, InstrValid=1, Retired=0.
- Sequential: with all decoder inputs 0, run 5 edges. Required: PC=0x00400014, ReadAddr=0x14, Instr=0x01093822, Retired=5.
- Jump: at PC 0x00400018 drive Jump=1, JumpValue=0x0100004. Required on the next edge: PC=0x00400010, ReadAddr=0x10, Instr=0x10A6FFFF.
- Branch: at PC 0x00400010 with SEImm=0xFFFFFFFF:
  - Branch=1, Zero=1 → PC remains 0x00400010 and Retired increments.
  - Branch=1, Zero=0 → PC becomes 0x00400014.
- Stall and ignored load: hold `stall`=1 for 3 edges in RUN while pulsing `load_we`. Required: PC, Retired and IMEM are unchanged; on release the PC advances by 4.
- Fault and reset: jump with JumpValue=0x0100040, giving target 0x00400100 with off=256 ≥ 256. Required:
  - Fault=1, InstrValid=0, PC is held at the jump's PC, Retired is unchanged.
  - Later edges and `start` have no effect.
  - Asserting `reset` gives state LOAD, PC=0x00400000, Fault=0.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit
// Instruction-fetch stage for the MIPS single-cycle core: byte-addressed
// big-endian IMEM, PC register with sequential/beq/jump next-PC selection,
// a LOAD phase for filling IMEM, stall, a range-fault stop and a
// saturating retired-instruction counter.

module mips_fetch_unit #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
    parameter int          CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              start,
    input  logic              stall,
    input  logic              Branch,
    input  logic              Zero,
    input  logic [31:0]       SEImm,
    input  logic              Jump,
    input  logic [25:0]       JumpValue,
    output logic [31:0]       PC,
    output logic [ADDR_W-1:0] ReadAddr,
    output logic [31:0]       Instr,
    output logic              InstrValid,
    output logic              Fault,
    output logic [CNT_W-1:0]  Retired
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam int          IMEM_BYTES = 2 ** ADDR_W;
    localparam logic [32:0] IMEM_LIMIT = 33'd1 << ADDR_W;

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_pc;
    logic [CNT_W-1:0]  r_retired;
    logic [7:0]        r_imem [0:IMEM_BYTES-1];

    logic [31:0]       w_pc4;
    logic [31:0]       w_next_pc;
    logic [31:0]       w_next_off;
    logic              w_in_range;
    logic              w_advance;
    logic [ADDR_W-1:0] w_read_addr;
    logic [ADDR_W-1:0] w_a1;
    logic [ADDR_W-1:0] w_a2;
    logic [ADDR_W-1:0] w_a3;

    // IMEM offset of the current PC and the three following byte addresses;
    // the byte addresses wrap around the end of IMEM.
    assign w_read_addr = ADDR_W'(r_pc - TEXT_BASE);
    assign w_a1        = w_read_addr + ADDR_W'(1);
    assign w_a2        = w_read_addr + ADDR_W'(2);
    assign w_a3        = w_read_addr + ADDR_W'(3);

    // Next-PC selection: jump beats a taken branch, which beats PC+4.
    always_comb begin
        w_pc4     = r_pc + 32'd4;
        w_next_pc = w_pc4;
        if (Jump) begin
            w_next_pc = {w_pc4[31:28], JumpValue, 2'b00};
        end else if (Branch && Zero) begin
            w_next_pc = w_pc4 + (SEImm << 2);
        end
    end

    // The target must land inside IMEM, measured from TEXT_BASE modulo 2**32.
    assign w_next_off = w_next_pc - TEXT_BASE;
    assign w_in_range = ({1'b0, w_next_off} < IMEM_LIMIT);

    // Control FSM: LOAD waits for start, RUN advances unless stalled or the
    // target is out of range, FAULT is only left through reset.
    always_comb begin
        w_next_state = r_state;
        w_advance    = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (w_in_range) begin
                        w_advance = 1'b1;
                    end else begin
                        w_next_state = S_FAULT;
                    end
                end
            end
            S_FAULT: begin
                w_next_state = S_FAULT;
            end
            default: begin
                w_next_state = S_LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // PC and retired counter move together; the counter sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= TEXT_BASE;
            r_retired <= '0;
        end else if (w_advance) begin
            r_pc <= w_next_pc;
            if (r_retired != {CNT_W{1'b1}}) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // IMEM is only writable in LOAD and deliberately survives reset.
    always_ff @(posedge clk) begin
        if ((r_state == S_LOAD) && load_we) begin
            r_imem[load_addr] <= load_data;
        end
    end

    assign PC         = r_pc;
    assign ReadAddr   = w_read_addr;
    assign Instr      = {r_imem[w_read_addr], r_imem[w_a1], r_imem[w_a2], r_imem[w_a3]};
    assign InstrValid = (r_state == S_RUN);
    assign Fault      = (r_state == S_FAULT);
    assign Retired    = r_retired;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit
// Directed bench for the fetch stage: load a short program, run it through
// sequential, jump and branch steps, stall, fault and reset. A second
// instance with a 2-bit counter shares every input to exercise saturation.

module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_we;
    logic [7:0]  load_addr;
    logic [7:0]  load_data;
    logic        start;
    logic        stall;
    logic        Branch;
    logic        Zero;
    logic [31:0] SEImm;
    logic        Jump;
    logic [25:0] JumpValue;
    logic [31:0] PC;
    logic [7:0]  ReadAddr;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        Fault;
    logic [31:0] Retired;

    logic [31:0] pc2;
    logic [7:0]  readAddr2;
    logic [31:0] instr2;
    logic        instrValid2;
    logic        fault2;
    logic [1:0]  retired2;

    int errors = 0;
    int checks = 0;

    logic [31:0] prog [0:6];

    mips_fetch_unit #(.ADDR_W(8), .TEXT_BASE(32'h0040_0000), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .start(start), .stall(stall), .Branch(Branch),
        .Zero(Zero), .SEImm(SEImm), .Jump(Jump), .JumpValue(JumpValue),
        .PC(PC), .ReadAddr(ReadAddr), .Instr(Instr), .InstrValid(InstrValid),
        .Fault(Fault), .Retired(Retired)
    );

    mips_fetch_unit #(.ADDR_W(8), .TEXT_BASE(32'h0040_0000), .CNT_W(2)) dutSat (
        .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .start(start), .stall(stall), .Branch(Branch),
        .Zero(Zero), .SEImm(SEImm), .Jump(Jump), .JumpValue(JumpValue),
        .PC(pc2), .ReadAddr(readAddr2), .Instr(instr2), .InstrValid(instrValid2),
        .Fault(fault2), .Retired(retired2)
    );

    always #5 clk = ~clk;

    // One active edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearDecoder();
        Branch    = 1'b0;
        Zero      = 1'b0;
        SEImm     = 32'h0;
        Jump      = 1'b0;
        JumpValue = 26'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_we = 1'b0; load_addr = 8'h0; load_data = 8'h0;
        start = 1'b0; stall = 1'b0;
        clearDecoder();
        #1;
        checks++; if (PC !== 32'h0040_0000) begin errors++; $display("[TB] FAIL reset_pc got=%h exp=%h", PC, 32'h0040_0000); end
        checks++; if (ReadAddr !== 8'h00) begin errors++; $display("[TB] FAIL reset_readaddr got=%h exp=00", ReadAddr); end
        checks++; if (InstrValid !== 1'b0 || Fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got=%b%b exp=00", InstrValid, Fault); end
        checks++; if (Retired !== 32'd0) begin errors++; $display("[TB] FAIL reset_retired got=%0d exp=0", Retired); end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load();
        logic [31:0] word;
        for (int i = 0; i < 28; i++) begin
            word      = prog[i / 4];
            load_addr = 8'(i);
            load_data = 8'(word >> (8 * (3 - (i % 4))));
            load_we   = 1'b1;
            start     = (i == 27);
            tick();
            if (i == 3) begin
                checks++; if (Instr !== 32'h02CD_F824) begin errors++; $display("[TB] FAIL load_visible got=%h exp=%h", Instr, 32'h02CD_F824); end
                checks++; if (PC !== 32'h0040_0000 || InstrValid !== 1'b0) begin errors++; $display("[TB] FAIL load_hold pc=%h valid=%b exp pc=00400000 valid=0", PC, InstrValid); end
            end
        end
        load_we = 1'b0;
        start   = 1'b0;
        checks++; if (PC !== 32'h0040_0000) begin errors++; $display("[TB] FAIL start_pc got=%h exp=00400000", PC); end
        checks++; if (Instr !== 32'h02CD_F824) begin errors++; $display("[TB] FAIL start_instr got=%h exp=02cdf824", Instr); end
        checks++; if (InstrValid !== 1'b1) begin errors++; $display("[TB] FAIL start_valid got=%b exp=1", InstrValid); end
        checks++; if (Retired !== 32'd0) begin errors++; $display("[TB] FAIL start_retired got=%0d exp=0", Retired); end
    endtask

    task automatic test_sequential();
        clearDecoder();
        for (int i = 0; i < 5; i++) tick();
        checks++; if (PC !== 32'h0040_0014) begin errors++; $display("[TB] FAIL seq_pc got=%h exp=00400014", PC); end
        checks++; if (ReadAddr !== 8'h14) begin errors++; $display("[TB] FAIL seq_readaddr got=%h exp=14", ReadAddr); end
        checks++; if (Instr !== 32'h0109_3822) begin errors++; $display("[TB] FAIL seq_instr got=%h exp=01093822", Instr); end
        checks++; if (Retired !== 32'd5) begin errors++; $display("[TB] FAIL seq_retired got=%0d exp=5", Retired); end
        checks++; if (retired2 !== 2'd3) begin errors++; $display("[TB] FAIL sat_retired got=%0d exp=3", retired2); end
        tick();
        checks++; if (PC !== 32'h0040_0018 || Instr !== 32'h0810_0004) begin errors++; $display("[TB] FAIL seq_last pc=%h instr=%h exp pc=00400018 instr=08100004", PC, Instr); end
        checks++; if (retired2 !== 2'd3) begin errors++; $display("[TB] FAIL sat_hold got=%0d exp=3", retired2); end
    endtask

    task automatic test_jump();
        Jump      = 1'b1;
        JumpValue = 26'h010_0004;
        tick();
        clearDecoder();
        checks++; if (PC !== 32'h0040_0010) begin errors++; $display("[TB] FAIL jump_pc got=%h exp=00400010", PC); end
        checks++; if (ReadAddr !== 8'h10) begin errors++; $display("[TB] FAIL jump_readaddr got=%h exp=10", ReadAddr); end
        checks++; if (Instr !== 32'h10A6_FFFF) begin errors++; $display("[TB] FAIL jump_instr got=%h exp=10a6ffff", Instr); end
        checks++; if (Retired !== 32'd7) begin errors++; $display("[TB] FAIL jump_retired got=%0d exp=7", Retired); end
    endtask

    task automatic test_branch();
        Branch = 1'b1;
        Zero   = 1'b1;
        SEImm  = 32'hFFFF_FFFF;
        tick();
        checks++; if (PC !== 32'h0040_0010) begin errors++; $display("[TB] FAIL beq_taken_pc got=%h exp=00400010", PC); end
        checks++; if (Retired !== 32'd8) begin errors++; $display("[TB] FAIL beq_taken_retired got=%0d exp=8", Retired); end
        Zero = 1'b0;
        tick();
        clearDecoder();
        checks++; if (PC !== 32'h0040_0014) begin errors++; $display("[TB] FAIL beq_nottaken_pc got=%h exp=00400014", PC); end
        checks++; if (Retired !== 32'd9) begin errors++; $display("[TB] FAIL beq_nottaken_retired got=%0d exp=9", Retired); end
    endtask

    task automatic test_stall_ignored_load();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_we   = 1'b1;
            load_addr = 8'h14 + 8'(i);
            load_data = 8'hA5;
            start     = 1'b1;
            tick();
            load_we = 1'b0;
            start   = 1'b0;
        end
        checks++; if (PC !== 32'h0040_0014) begin errors++; $display("[TB] FAIL stall_pc got=%h exp=00400014", PC); end
        checks++; if (Retired !== 32'd9) begin errors++; $display("[TB] FAIL stall_retired got=%0d exp=9", Retired); end
        checks++; if (Instr !== 32'h0109_3822) begin errors++; $display("[TB] FAIL stall_imem got=%h exp=01093822", Instr); end
        stall = 1'b0;
        tick();
        checks++; if (PC !== 32'h0040_0018 || Retired !== 32'd10) begin errors++; $display("[TB] FAIL stall_release pc=%h ret=%0d exp pc=00400018 ret=10", PC, Retired); end
    endtask

    task automatic test_fault();
        Jump      = 1'b1;
        JumpValue = 26'h010_0040;
        tick();
        checks++; if (Fault !== 1'b1 || InstrValid !== 1'b0) begin errors++; $display("[TB] FAIL fault_flags got fault=%b valid=%b exp fault=1 valid=0", Fault, InstrValid); end
        checks++; if (PC !== 32'h0040_0018) begin errors++; $display("[TB] FAIL fault_pc got=%h exp=00400018", PC); end
        checks++; if (Retired !== 32'd10) begin errors++; $display("[TB] FAIL fault_retired got=%0d exp=10", Retired); end
        clearDecoder();
        start = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        start = 1'b0;
        checks++; if (Fault !== 1'b1 || PC !== 32'h0040_0018 || Retired !== 32'd10) begin errors++; $display("[TB] FAIL fault_sticky fault=%b pc=%h ret=%0d exp 1 00400018 10", Fault, PC, Retired); end
    endtask

    task automatic test_reset_from_fault();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (PC !== 32'h0040_0000 || Fault !== 1'b0) begin errors++; $display("[TB] FAIL rst_async pc=%h fault=%b exp 00400000 0", PC, Fault); end
        checks++; if (InstrValid !== 1'b0 || Retired !== 32'd0) begin errors++; $display("[TB] FAIL rst_state valid=%b ret=%0d exp 0 0", InstrValid, Retired); end
        checks++; if (Instr !== 32'h02CD_F824) begin errors++; $display("[TB] FAIL rst_imem_kept got=%h exp=02cdf824", Instr); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if (InstrValid !== 1'b0 || PC !== 32'h0040_0000) begin errors++; $display("[TB] FAIL rst_in_load valid=%b pc=%h exp 0 00400000", InstrValid, PC); end
    endtask

    initial begin
        prog[0] = 32'h02CD_F824;
        prog[1] = 32'h0043_082A;
        prog[2] = 32'h8E8C_0014;
        prog[3] = 32'hAC04_0000;
        prog[4] = 32'h10A6_FFFF;
        prog[5] = 32'h0109_3822;
        prog[6] = 32'h0810_0004;
        test_reset();
        test_load();
        test_sequential();
        test_jump();
        test_branch();
        test_stall_ignored_load();
        test_fault();
        test_reset_from_fault();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
